// File: rtl/irrigation_sequencer.sv
// Timed sequencer for the irrigation actuators: settle window, bounded run, mandatory
// rest, latched sensor-conflict fault, and the saturating 3-bit irrigation cycle counter.
module irrigation_sequencer #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned SETTLE_TICKS = 3,
  parameter int unsigned RUN_TICKS    = 10,
  parameter int unsigned REST_TICKS   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic irrigation_request,
  input  logic splinker_mode_request,
  input  logic conflicting_values,
  input  logic counter_clear,
  output logic splinker_bomb,
  output logic dripper_valvule,
  output logic counter_2,
  output logic counter_1,
  output logic counter_0,
  output logic busy,
  output logic fault
);

  localparam int unsigned MAX_SR    = (SETTLE_TICKS > RUN_TICKS) ? SETTLE_TICKS : RUN_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_SR > REST_TICKS) ? MAX_SR : REST_TICKS;
  localparam int unsigned PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int unsigned CW        = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_RUN    = 3'd2,
    S_REST   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state, state_next;
  logic          mode, mode_next;
  logic [PW-1:0] presc, presc_next;
  logic [TW-1:0] timer, timer_next;
  logic [TW-1:0] limit_m1;
  logic          tick;
  logic          expired;
  logic          restart;
  logic [CW-1:0] count, count_next;
  logic          splinker_d, dripper_d, busy_d, fault_d;

  // State, latched mode and tick/timer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      mode  <= 1'b0;
      presc <= '0;
      timer <= '0;
    end else begin
      state <= state_next;
      mode  <= mode_next;
      presc <= presc_next;
      timer <= timer_next;
    end
  end

  // Duration of the current state, in ticks minus one
  always_comb begin
    limit_m1 = '0;
    case (state)
      S_SETTLE: limit_m1 = TW'(SETTLE_TICKS - 1);
      S_FAULT:  limit_m1 = TW'(SETTLE_TICKS - 1);
      S_RUN:    limit_m1 = TW'(RUN_TICKS - 1);
      S_REST:   limit_m1 = TW'(REST_TICKS - 1);
      default:  limit_m1 = '0;
    endcase
  end

  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign expired = tick && (timer == limit_m1);

  // Next-state logic; priority is conflict, then request loss, then timer expiry
  always_comb begin
    state_next = state;
    mode_next  = mode;
    restart    = 1'b0;
    presc_next = tick ? '0 : presc + PW'(1);
    timer_next = tick ? timer + TW'(1) : timer;

    case (state)
      S_IDLE: begin
        if (conflicting_values) begin
          state_next = S_FAULT;
        end else if (irrigation_request) begin
          state_next = S_SETTLE;
          mode_next  = splinker_mode_request;
        end
      end
      S_SETTLE: begin
        if (conflicting_values) begin
          state_next = S_FAULT;
        end else if (!irrigation_request || (splinker_mode_request != mode)) begin
          state_next = S_IDLE;
        end else if (expired) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (conflicting_values) begin
          state_next = S_FAULT;
        end else if (!irrigation_request || expired) begin
          state_next = S_REST;
        end
      end
      S_REST: begin
        if (conflicting_values) begin
          state_next = S_FAULT;
        end else if (expired) begin
          state_next = S_IDLE;
        end
      end
      S_FAULT: begin
        if (conflicting_values) begin
          restart = 1'b1;
        end else if (expired) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Timing restarts on every state entry and on each conflict seen while faulted
    if ((state_next != state) || (state == S_IDLE) || restart) begin
      presc_next = '0;
      timer_next = '0;
    end
  end

  // Output decode from the next state so every output is registered alongside state
  always_comb begin
    busy_d     = (state_next != S_IDLE);
    fault_d    = (state_next == S_FAULT);
    splinker_d = (state_next == S_RUN) && mode_next;
    dripper_d  = (state_next == S_RUN) && !mode_next;
    count_next = count;
    if (counter_clear) begin
      count_next = '0;
    end else if ((state_next == S_RUN) && (state != S_RUN) && (count != '1)) begin
      count_next = count + CW'(1);
    end
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      splinker_bomb   <= 1'b0;
      dripper_valvule <= 1'b0;
      busy            <= 1'b0;
      fault           <= 1'b0;
      count           <= '0;
    end else begin
      splinker_bomb   <= splinker_d;
      dripper_valvule <= dripper_d;
      busy            <= busy_d;
      fault           <= fault_d;
      count           <= count_next;
    end
  end

  assign {counter_2, counter_1, counter_0} = count;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Scoreboard bench for irrigation_sequencer: stimulus queues hand-computed expected
// output vectors per cycle, a negedge monitor pops and compares them.
module tb_irrigation_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic irrigation_request = 1'b0;
  logic splinker_mode_request = 1'b0;
  logic conflicting_values = 1'b0;
  logic counter_clear = 1'b0;
  logic splinker_bomb, dripper_valvule, counter_2, counter_1, counter_0, busy, fault;

  irrigation_sequencer #(
    .TICK_DIV(4), .SETTLE_TICKS(2), .RUN_TICKS(3), .REST_TICKS(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .irrigation_request(irrigation_request),
    .splinker_mode_request(splinker_mode_request),
    .conflicting_values(conflicting_values),
    .counter_clear(counter_clear),
    .splinker_bomb(splinker_bomb),
    .dripper_valvule(dripper_valvule),
    .counter_2(counter_2),
    .counter_1(counter_1),
    .counter_0(counter_0),
    .busy(busy),
    .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Observed vector: busy, fault, sprinkler, dripper, counter[2:0]
  function automatic logic [6:0] o(input logic b, input logic f, input logic s,
                                   input logic d, input int c);
    logic [2:0] cv;
    cv = 3'(c);
    return {b, f, s, d, cv};
  endfunction

  // Monitor: compare every expectation queued for the current cycle
  always @(negedge clock) begin
    logic [6:0] obs;
    exp_t e;
    obs = {busy, fault, splinker_bomb, dripper_valvule, counter_2, counter_1, counter_0};
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", e.name, e.cyc, cyc);
      end else if (obs !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=%b required=%b (busy,fault,spr,drip,cnt)",
                 e.name, cyc, obs, e.exp);
      end
    end
    if (!reset) begin
      checks++;
      if (splinker_bomb === 1'b1 && dripper_valvule === 1'b1) begin
        failures++;
        $display("FAIL both_actuators cyc=%0d actual=11 required=not both high", cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input int n, input string name, input logic [6:0] exp);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      step();
      e.cyc  = cyc;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
    end
  endtask

  task automatic drive(input logic req, input logic mode, input logic conf);
    irrigation_request    = req;
    splinker_mode_request = mode;
    conflicting_values    = conf;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    hold(1, "reset", o(0, 0, 0, 0, 0));
    reset = 1'b0;
  endtask

  initial begin
    // Reset and idle hold
    do_reset();
    hold(20, "idle_hold", o(0, 0, 0, 0, 0));

    // Full sprinkler cycle with re-arm
    drive(1'b1, 1'b1, 1'b0);
    hold(8, "settle1", o(1, 0, 0, 0, 0));
    hold(12, "run1", o(1, 0, 1, 0, 1));
    hold(8, "rest1", o(1, 0, 0, 0, 1));
    hold(1, "idle1", o(0, 0, 0, 0, 1));
    hold(8, "settle2", o(1, 0, 0, 0, 1));
    hold(12, "run2", o(1, 0, 1, 0, 2));
    drive(1'b0, 1'b1, 1'b0);
    hold(8, "rest2", o(1, 0, 0, 0, 2));
    hold(3, "idle2", o(0, 0, 0, 0, 2));

    // Glitch rejection: short request
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    hold(5, "glitch_settle", o(1, 0, 0, 0, 0));
    drive(1'b0, 1'b1, 1'b0);
    hold(4, "glitch_idle", o(0, 0, 0, 0, 0));

    // Glitch rejection: mode flip drops to IDLE, then re-arms with the new mode
    drive(1'b1, 1'b1, 1'b0);
    hold(2, "flip_settle", o(1, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b0);
    hold(1, "flip_idle", o(0, 0, 0, 0, 0));
    hold(2, "flip_rearm", o(1, 0, 0, 0, 0));
    drive(1'b0, 1'b0, 1'b0);
    hold(4, "flip_end", o(0, 0, 0, 0, 0));

    // Dripper run with ignored mode change and early stop
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    hold(8, "drip_settle", o(1, 0, 0, 0, 0));
    hold(2, "drip_run", o(1, 0, 0, 1, 1));
    drive(1'b1, 1'b1, 1'b0);
    hold(3, "drip_run_modechg", o(1, 0, 0, 1, 1));
    drive(1'b0, 1'b1, 1'b0);
    hold(8, "drip_rest", o(1, 0, 0, 0, 1));
    hold(2, "drip_idle", o(0, 0, 0, 0, 1));

    // Fault during RUN, release, reassert, final release
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    hold(8, "f_settle", o(1, 0, 0, 0, 0));
    hold(2, "f_run", o(1, 0, 1, 0, 1));
    drive(1'b1, 1'b1, 1'b1);
    hold(1, "f_enter", o(1, 1, 0, 0, 1));
    drive(1'b0, 1'b1, 1'b0);
    hold(4, "f_release1", o(1, 1, 0, 0, 1));
    drive(1'b0, 1'b1, 1'b1);
    hold(1, "f_reassert", o(1, 1, 0, 0, 1));
    drive(1'b0, 1'b1, 1'b0);
    hold(7, "f_window", o(1, 1, 0, 0, 1));
    hold(3, "f_cleared", o(0, 0, 0, 0, 1));

    // Counter saturation over nine back-to-back cycles
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      int prev_c;
      int cur_c;
      prev_c = (k - 1 > 7) ? 7 : k - 1;
      cur_c  = (k > 7) ? 7 : k;
      hold(8, "sat_settle", o(1, 0, 0, 0, prev_c));
      hold(12, "sat_run", o(1, 0, 1, 0, cur_c));
      hold(8, "sat_rest", o(1, 0, 0, 0, cur_c));
      hold(1, "sat_idle", o(0, 0, 0, 0, cur_c));
    end

    // Clear coinciding with RUN entry wins over the increment
    hold(8, "clr_settle", o(1, 0, 0, 0, 7));
    counter_clear = 1'b1;
    hold(1, "clr_run_entry", o(1, 0, 1, 0, 0));
    counter_clear = 1'b0;
    hold(3, "clr_run", o(1, 0, 1, 0, 0));

    // Reset mid-RUN zeroes everything immediately, no REST
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    hold(1, "rst_mid_run", o(0, 0, 0, 0, 0));
    reset = 1'b0;
    hold(3, "rst_after", o(0, 0, 0, 0, 0));

    @(negedge clock);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
